// File: rtl/shared_reg_reader_pkg.sv
// -----------------------------------------------------------------------------
// wwr_pkg
//
// Shared definitions for the shared_reg_reader slice: reader count, the
// reset value of the stored word, the one-hot grant encoding used on rd_gnt,
// the default collision counter width and the round-robin pointer type.
//
// Optional feature macro referenced by users of this package:
//   WWR_COLLISION_EN  -- enables the write-collision pulse and counter.
// -----------------------------------------------------------------------------
package wwr_pkg;

    // Number of independent readers served by the arbiter.
    localparam int NRD = 2;

    // Reset value of the shared word; sliced down to the instance width.
    localparam logic [31:0] VALUE_RST = 32'h0000_0000;

    // One-hot grant / request encodings on a 2-reader port.
    localparam logic [NRD-1:0] GNT_NONE = 2'b00;
    localparam logic [NRD-1:0] GNT_RD0  = 2'b01;
    localparam logic [NRD-1:0] GNT_RD1  = 2'b10;
    localparam logic [NRD-1:0] REQ_BOTH = 2'b11;

    // Default width of the saturating collision counter.
    localparam int CNT_W_DEF = 8;

    // Round-robin pointer: names the reader that wins the next contested cycle.
    typedef enum logic {
        PTR_RD0 = 1'b0,
        PTR_RD1 = 1'b1
    } rr_ptr_e;

    // Grant vector handed to the reader the pointer currently favours.
    function automatic logic [NRD-1:0] ptr_to_gnt(input rr_ptr_e ptr);
        if (ptr == PTR_RD0) begin
            return GNT_RD0;
        end
        return GNT_RD1;
    endfunction

endpackage

// File: rtl/shared_reg_reader_if.sv
// -----------------------------------------------------------------------------
// shared_reg_reader_if
//
// Bundles the write sources, the reader req/grant port and the observation
// outputs of shared_reg_reader. clk and rst are kept outside the interface.
//
// Signals:
//   wr1_en / wr1_data   write source 1 (lower priority)
//   wr2_en / wr2_data   write source 2 (higher priority)
//   rd_req              per-reader level request, held until granted
//   rd_gnt              registered one-hot grant, marks valid read data
//   rd_data             registered read data
//   rd_fresh            value changed since the granted reader's last read
//   value               current stored word
//   wr_collision        (WWR_COLLISION_EN) both writers enabled last cycle
//   coll_cnt            (WWR_COLLISION_EN) saturating collision count
//
// Modports:
//   master -- the environment: drives writes and requests.
//   slave  -- the register: drives grants, read data and observation outputs.
//
// Optional feature macro: WWR_COLLISION_EN.
// -----------------------------------------------------------------------------
interface shared_reg_reader_if
    import wwr_pkg::*;
#(
    parameter int W = 1
`ifdef WWR_COLLISION_EN
    , parameter int CNT_W = CNT_W_DEF
`endif
) ();

    logic           wr1_en;
    logic [W-1:0]   wr1_data;
    logic           wr2_en;
    logic [W-1:0]   wr2_data;
    logic [NRD-1:0] rd_req;
    logic [NRD-1:0] rd_gnt;
    logic [W-1:0]   rd_data;
    logic           rd_fresh;
    logic [W-1:0]   value;

`ifdef WWR_COLLISION_EN
    logic             wr_collision;
    logic [CNT_W-1:0] coll_cnt;

    modport master (
        output wr1_en, wr1_data, wr2_en, wr2_data, rd_req,
        input  rd_gnt, rd_data, rd_fresh, value, wr_collision, coll_cnt
    );

    modport slave (
        input  wr1_en, wr1_data, wr2_en, wr2_data, rd_req,
        output rd_gnt, rd_data, rd_fresh, value, wr_collision, coll_cnt
    );
`else
    modport master (
        output wr1_en, wr1_data, wr2_en, wr2_data, rd_req,
        input  rd_gnt, rd_data, rd_fresh, value
    );

    modport slave (
        input  wr1_en, wr1_data, wr2_en, wr2_data, rd_req,
        output rd_gnt, rd_data, rd_fresh, value
    );
`endif

endinterface

// File: rtl/shared_reg_reader_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
//
// Two-requester round-robin arbiter with a registered one-hot grant.
// A lone requester always wins. When both request, the reader named by the
// round-robin pointer wins and the pointer flips; uncontested grants leave the
// pointer alone. The grant decided this cycle (gnt_next) is also exported so
// the owner can capture read data and freshness at the same edge the
// registered grant (gnt) rises.
//
// Ports:
//   clk       in   clock
//   rst       in   synchronous active-high reset (pointer -> reader 0)
//   req       in   per-reader request, level
//   gnt_next  out  grant being decided this cycle (combinational)
//   gnt       out  registered grant, visible one cycle after req
// -----------------------------------------------------------------------------
module rr_arb2
    import wwr_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic [NRD-1:0] req,
    output logic [NRD-1:0] gnt_next,
    output logic [NRD-1:0] gnt
);

    rr_ptr_e ptr_q;
    rr_ptr_e ptr_next;

    // Pointer state and registered grant; reset suppresses any grant decided
    // in the reset cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= PTR_RD0;
            gnt   <= GNT_NONE;
        end else begin
            ptr_q <= ptr_next;
            gnt   <= gnt_next;
        end
    end

    always_comb begin
        gnt_next = GNT_NONE;
        ptr_next = ptr_q;
        case (req)
            GNT_RD0: gnt_next = GNT_RD0;
            GNT_RD1: gnt_next = GNT_RD1;
            REQ_BOTH: begin
                gnt_next = ptr_to_gnt(ptr_q);
                // Only a contested grant hands priority to the other reader.
                if (ptr_q == PTR_RD0) begin
                    ptr_next = PTR_RD1;
                end else begin
                    ptr_next = PTR_RD0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/shared_reg_reader.sv
// -----------------------------------------------------------------------------
// shared_reg_reader
//
// Golden read-side model of the multi-writer shared register. One W-bit word
// is written by two sources with fixed priority (rst > wr2 > wr1 > hold) and
// read by two readers through a round-robin req/grant port. Read data, grant
// and a per-reader "fresh" flag are registered and appear one cycle after the
// request. A reader granted from cycle N sees the word as stored before
// cycle N's write.
//
// Ports:
//   clk   in   clock, rising edge
//   rst   in   synchronous active-high reset
//   bus   slave modport of shared_reg_reader_if (writes, reads, value,
//         and with WWR_COLLISION_EN also wr_collision / coll_cnt)
//
// Parameters:
//   W      width of the shared word (1..32)
//   CNT_W  collision counter width (only with WWR_COLLISION_EN)
//
// Optional feature macro: WWR_COLLISION_EN -- adds a registered pulse for
// cycles in which both writers were enabled and a saturating count of them.
// -----------------------------------------------------------------------------
module shared_reg_reader
    import wwr_pkg::*;
#(
    parameter int W = 1
`ifdef WWR_COLLISION_EN
    , parameter int CNT_W = CNT_W_DEF
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    shared_reg_reader_if.slave   bus
);

`ifdef WWR_COLLISION_EN
    // Saturating increment: the count sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        if (&cnt) begin
            return cnt;
        end
        return cnt + CNT_W'(1);
    endfunction
`endif

    logic [W-1:0]   value_q;
    logic           wr_any;
    logic [NRD-1:0] seen_q;
    logic [NRD-1:0] gnt_p0;
    logic [NRD-1:0] gnt_p1;
    logic [W-1:0]   rd_data_p1;
    logic           rd_fresh_p1;

    // Either write commits this cycle; value change is not required to
    // invalidate the readers' seen bits.
    assign wr_any = bus.wr1_en | bus.wr2_en;

    // ---- p0: storage with write priority ---------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= VALUE_RST[W-1:0];
        end else if (bus.wr2_en) begin
            value_q <= bus.wr2_data;
        end else if (bus.wr1_en) begin
            value_q <= bus.wr1_data;
        end
    end

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      (bus.rd_req),
        .gnt_next (gnt_p0),
        .gnt      (gnt_p1)
    );

    // ---- p1: read capture and fresh tracking -----------------------------
    // rd_data samples value_q before this edge's write lands, giving the
    // old-data read-during-write behaviour. A write in the grant cycle clears
    // seen after the grant would have set it, so the write wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_p1  <= VALUE_RST[W-1:0];
            rd_fresh_p1 <= 1'b0;
            seen_q      <= '0;
        end else begin
            if (gnt_p0 != GNT_NONE) begin
                rd_data_p1 <= value_q;
            end
            rd_fresh_p1 <= |(gnt_p0 & ~seen_q);
            if (wr_any) begin
                seen_q <= '0;
            end else begin
                seen_q <= seen_q | gnt_p0;
            end
        end
    end

    assign bus.value    = value_q;
    assign bus.rd_gnt   = gnt_p1;
    assign bus.rd_data  = rd_data_p1;
    assign bus.rd_fresh = rd_fresh_p1;

`ifdef WWR_COLLISION_EN
    logic             coll_p0;
    logic             wr_collision_p1;
    logic [CNT_W-1:0] coll_cnt_q;

    assign coll_p0 = bus.wr1_en & bus.wr2_en & ~rst;

    // ---- p1: collision pulse and saturating count ------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_collision_p1 <= 1'b0;
            coll_cnt_q      <= '0;
        end else begin
            wr_collision_p1 <= coll_p0;
            if (coll_p0) begin
                coll_cnt_q <= sat_inc(coll_cnt_q);
            end
        end
    end

    assign bus.wr_collision = wr_collision_p1;
    assign bus.coll_cnt     = coll_cnt_q;
`endif

endmodule
